// File: rtl/fft_shift_pingpong.sv
// Ping-pong frame store that reads each frame back in FFT-shifted order.
// Define FFT_SHIFT_MODE_SEL_EN to add i_Shift_En (per-frame natural/shifted select).
module fft_shift_pingpong #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 128
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Wr_DV,
    input  logic [WIDTH-1:0] i_Wr_Data,
    input  logic             i_Rd_En,
`ifdef FFT_SHIFT_MODE_SEL_EN
    input  logic             i_Shift_En,
`endif
    output logic             o_Rd_DV,
    output logic [WIDTH-1:0] o_Rd_Data,
    output logic             o_Rd_SOF,
    output logic             o_Rd_EOF,
    output logic             o_Frame_Rdy,
    output logic             o_Overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] HALF = AW'(DEPTH / 2);

    logic [WIDTH-1:0] r_Mem [0:2*DEPTH-1];
    logic [1:0]       r_Full;
    logic             r_Wr_Bank;
    logic             r_Rd_Bank;
    logic [AW-1:0]    r_Wr_Cnt;
    logic [AW-1:0]    r_Rd_Cnt;

    logic             w_Wr_Ok;
    logic             w_Wr_Last;
    logic             w_Rd_Issue;
    logic             w_Rd_Last;
    logic             w_Shift;
    logic [AW-1:0]    w_Rd_Addr;

    assign w_Wr_Ok    = i_Wr_DV & ~r_Full[r_Wr_Bank];
    assign w_Wr_Last  = w_Wr_Ok & (r_Wr_Cnt == LAST);
    assign w_Rd_Issue = i_Rd_En & r_Full[r_Rd_Bank];
    assign w_Rd_Last  = w_Rd_Issue & (r_Rd_Cnt == LAST);

`ifdef FFT_SHIFT_MODE_SEL_EN
    logic r_Shift;

    // Mode is captured on the first read of a frame and held to its end
    assign w_Shift = (r_Rd_Cnt == '0) ? i_Shift_En : r_Shift;

    always_ff @(posedge i_Clk) begin
        if (i_Rst)
            r_Shift <= 1'b1;
        else if (w_Rd_Issue && r_Rd_Cnt == '0)
            r_Shift <= i_Shift_En;
    end
`else
    assign w_Shift = 1'b1;
`endif

    assign w_Rd_Addr   = w_Shift ? (r_Rd_Cnt + HALF) : r_Rd_Cnt;
    assign o_Frame_Rdy = |r_Full;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst && w_Wr_Ok)
            r_Mem[{r_Wr_Bank, r_Wr_Cnt}] <= i_Wr_Data;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Wr_Bank <= 1'b0;
            r_Wr_Cnt  <= '0;
        end else if (w_Wr_Ok) begin
            r_Wr_Cnt <= w_Wr_Last ? '0 : r_Wr_Cnt + 1'b1;
            if (w_Wr_Last)
                r_Wr_Bank <= ~r_Wr_Bank;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Rd_Bank <= 1'b0;
            r_Rd_Cnt  <= '0;
        end else if (w_Rd_Issue) begin
            r_Rd_Cnt <= w_Rd_Last ? '0 : r_Rd_Cnt + 1'b1;
            if (w_Rd_Last)
                r_Rd_Bank <= ~r_Rd_Bank;
        end
    end

    // Completing and finishing banks never coincide on the same bank
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Full <= '0;
        end else begin
            if (w_Wr_Last)
                r_Full[r_Wr_Bank] <= 1'b1;
            if (w_Rd_Last)
                r_Full[r_Rd_Bank] <= 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Rd_DV    <= 1'b0;
            o_Rd_Data  <= '0;
            o_Rd_SOF   <= 1'b0;
            o_Rd_EOF   <= 1'b0;
            o_Overflow <= 1'b0;
        end else begin
            o_Rd_DV    <= w_Rd_Issue;
            o_Rd_Data  <= w_Rd_Issue ? r_Mem[{r_Rd_Bank, w_Rd_Addr}] : '0;
            o_Rd_SOF   <= w_Rd_Issue & (r_Rd_Cnt == '0);
            o_Rd_EOF   <= w_Rd_Last;
            o_Overflow <= i_Wr_DV & r_Full[r_Wr_Bank];
        end
    end

endmodule

// File: tb/tb_fft_shift_pingpong.sv
// Bench for fft_shift_pingpong: frame-queue reference model, directed and random steps.
module tb_fft_shift_pingpong;

    localparam int W = 16;
    localparam int D = 8;

    typedef logic [W-1:0] frame_t [D];

    logic         clk = 1'b0;
    logic         i_Rst = 1'b1;
    logic         i_Wr_DV = 1'b0;
    logic [W-1:0] i_Wr_Data = '0;
    logic         i_Rd_En = 1'b0;
    logic         o_Rd_DV;
    logic [W-1:0] o_Rd_Data;
    logic         o_Rd_SOF;
    logic         o_Rd_EOF;
    logic         o_Frame_Rdy;
    logic         o_Overflow;

    int n_cmp = 0;
    int n_err = 0;

    frame_t fq[$];
    frame_t part;
    int     pcnt = 0;
    int     ridx = 0;

    fft_shift_pingpong #(.WIDTH(W), .DEPTH(D)) dut (
        .i_Clk(clk),
        .i_Rst(i_Rst),
        .i_Wr_DV(i_Wr_DV),
        .i_Wr_Data(i_Wr_Data),
        .i_Rd_En(i_Rd_En),
        .o_Rd_DV(o_Rd_DV),
        .o_Rd_Data(o_Rd_Data),
        .o_Rd_SOF(o_Rd_SOF),
        .o_Rd_EOF(o_Rd_EOF),
        .o_Frame_Rdy(o_Frame_Rdy),
        .o_Overflow(o_Overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input logic dv, input logic [W-1:0] data,
                             input logic sof, input logic eof,
                             input logic rdy, input logic ovf);
        chk("rd_dv", 32'(o_Rd_DV), 32'(dv));
        chk("rd_data", 32'(o_Rd_Data), 32'(data));
        chk("rd_sof", 32'(o_Rd_SOF), 32'(sof));
        chk("rd_eof", 32'(o_Rd_EOF), 32'(eof));
        chk("frame_rdy", 32'(o_Frame_Rdy), 32'(rdy));
        chk("overflow", 32'(o_Overflow), 32'(ovf));
    endtask

    // One clock: model reacts to pre-edge state, outputs checked #1 after edge
    task automatic step(input logic wdv, input logic [W-1:0] wd, input logic ren);
        int n;
        logic drop, iss, e_sof, e_eof;
        logic [W-1:0] e_data;
        i_Wr_DV = wdv;
        i_Wr_Data = wd;
        i_Rd_En = ren;
        n = fq.size();
        drop = wdv && (n == 2);
        iss = ren && (n > 0);
        e_data = '0;
        e_sof = 1'b0;
        e_eof = 1'b0;
        if (iss) begin
            e_data = fq[0][(ridx + D / 2) % D];
            e_sof = (ridx == 0);
            e_eof = (ridx == D - 1);
            ridx++;
            if (ridx == D) begin
                fq.delete(0);
                ridx = 0;
            end
        end
        if (wdv && !drop) begin
            part[pcnt] = wd;
            pcnt++;
            if (pcnt == D) begin
                fq.push_back(part);
                pcnt = 0;
            end
        end
        @(posedge clk);
        #1;
        check_all(iss, e_data, e_sof, e_eof, fq.size() > 0, drop);
    endtask

    task automatic do_reset();
        i_Rst = 1'b1;
        i_Wr_DV = 1'b0;
        i_Rd_En = 1'b0;
        @(posedge clk);
        #1;
        i_Rst = 1'b0;
        fq.delete();
        pcnt = 0;
        ridx = 0;
        check_all(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Basic shifted read-out of 0..7
        do_reset();
        for (int i = 0; i < D; i++) step(1'b1, W'(i), 1'b0);
        for (int i = 0; i < D + 2; i++) step(1'b0, '0, 1'b1);

        // Two full banks, then an overflowing ninth sample
        for (int i = 0; i < D; i++) step(1'b1, W'(10 + i), 1'b0);
        for (int i = 0; i < D; i++) step(1'b1, W'(20 + i), 1'b0);
        step(1'b1, W'(99), 1'b0);
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < 2 * D + 2; i++) step(1'b0, '0, 1'b1);

        // Continuous write and read, four frames
        for (int i = 0; i < 4 * D; i++) step(1'b1, W'(100 + i), 1'b1);
        for (int i = 0; i < D + 2; i++) step(1'b0, '0, 1'b1);

        // Toggled read enable
        for (int i = 0; i < D; i++) step(1'b1, W'(200 + i), 1'b0);
        for (int i = 0; i < 2 * D + 2; i++) step(1'b0, '0, 1'(i % 2 == 0));

        // Full-bank write colliding with the final read of that bank
        for (int i = 0; i < 2 * D; i++) step(1'b1, W'(300 + i), 1'b0);
        for (int i = 0; i < D; i++) step(1'b1, W'(400 + i), 1'b1);
        for (int i = 0; i < 2 * D + 2; i++) step(1'b0, '0, 1'b1);

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 5; i++) step(1'b1, W'(50 + i), 1'b0);
        do_reset();
        for (int i = 0; i < D; i++) step(1'b1, W'(30 + i), 1'b0);
        for (int i = 0; i < D + 2; i++) step(1'b0, '0, 1'b1);

        // Random traffic
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 3) != 0), W'($urandom),
                 1'($urandom_range(0, 2) != 0));
        for (int i = 0; i < 3 * D; i++) step(1'b0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_shift_pingpong.md
# fft_shift_pingpong

Single-clock, double-buffered frame store that reorders each N-sample frame into FFT-shifted order (upper half first, then lower half). Sits between the FFT core output and downstream spectrum consumers. Successor to the plain dual-port sample RAM: it adds automatic addressing, two-bank ping-pong buffering, frame markers, overflow reporting and back-pressured read-out.

## Interface
- WIDTH, 16, sample width in bits
- DEPTH, 128, frame length N; power of two, at least 4
- i_Clk  in  1  sole clock, all logic on rising edge
- i_Rst  in  1  synchronous reset, active-high
- i_Wr_DV  in  1  input sample valid
- i_Wr_Data  in  WIDTH  input sample, natural bin order
- i_Rd_En  in  1  consumer requests one sample this cycle
- i_Shift_En  in  1  1 = shifted order, 0 = natural order (present only with macro, see Configuration)
- o_Rd_DV  out  1  o_Rd_Data valid
- o_Rd_Data  out  WIDTH  output sample
- o_Rd_SOF  out  1  first sample of an output frame, qualified by o_Rd_DV
- o_Rd_EOF  out  1  last sample of an output frame, qualified by o_Rd_DV
- o_Frame_Rdy  out  1  at least one bank is FULL
- o_Overflow  out  1  one-cycle pulse when an input sample is dropped

## Operation
- Two banks of DEPTH x WIDTH; each bank has a full flag. Write bank pointer wr_bank, read bank pointer rd_bank, write counter wr_cnt, read counter rd_cnt, all $clog2(DEPTH) bits except the bank bits.
- Write: on i_Wr_DV, if bank[wr_bank] is not full, store at address wr_cnt and increment. On wr_cnt == DEPTH-1, set full[wr_bank], toggle wr_bank, reset wr_cnt to 0.
- If i_Wr_DV arrives while bank[wr_bank] is full, the sample is dropped. o_Overflow pulses for 1 cycle and wr_cnt does not advance.
- Read: a read is issued when i_Rd_En=1 and full[rd_bank]=1.
  - Shifted order: RAM address = (rd_cnt + DEPTH/2) mod DEPTH, using the low $clog2(DEPTH) bits.
  - Natural order: RAM address = rd_cnt.
- On issue of rd_cnt == DEPTH-1: clear full[rd_bank], toggle rd_bank, reset rd_cnt to 0.
- i_Rd_En with no full bank: no read, no error, o_Rd_DV=0.
- Markers: o_Rd_SOF when the issued rd_cnt was 0; o_Rd_EOF when it was DEPTH-1.
- Simultaneous events:
  - Write completing one bank and read finishing the other in the same cycle: both take effect.
  - A write aimed at a bank whose final read is issued that cycle is dropped. The bank is still full that cycle, so o_Overflow pulses.
- Reset mid-frame:
  - Full flags, pointers and counters go to 0. The partial frame is discarded.
  - RAM contents are not cleared.

## Timing
- Reset values: o_Rd_DV=0, o_Rd_Data=0, o_Rd_SOF=0, o_Rd_EOF=0, o_Frame_Rdy=0, o_Overflow=0.
- Read latency is 1 cycle: a read issued at edge t gives o_Rd_DV, o_Rd_Data, o_Rd_SOF and o_Rd_EOF registered at t+1.
- Any cycle with no read issued: o_Rd_DV=0, o_Rd_Data=0, o_Rd_SOF=0, o_Rd_EOF=0.
- The last write of a frame at edge t makes o_Frame_Rdy=1 and the bank readable from cycle t+1.
- A bank freed by a final read issued at edge t is writable from cycle t+1.
- o_Overflow is registered, asserted the cycle after the dropped sample.
- Full-rate throughput: one write per cycle and one read per cycle, sustained indefinitely.

## Configuration
- FFT_SHIFT_MODE_SEL_EN defined:
  - The i_Shift_En port exists.
  - i_Shift_En is sampled only when a read with rd_cnt == 0 is issued, and is held for the whole frame.
  - Changing it mid-frame has no effect until the next frame.
- FFT_SHIFT_MODE_SEL_EN undefined: the port is absent and the order is always shifted.

## Test plan
- DEPTH=8, write 0..7 back-to-back, then i_Rd_En=1 -> o_Rd_Data 4,5,6,7,0,1,2,3, one per cycle starting 1 cycle after the first issue; SOF on 4, EOF on 3.
- Write frames A (10..17) and B (20..27) with no reads, then a 9th sample -> o_Overflow 1-cycle pulse, o_Frame_Rdy=1; reading gives 14..17,10..13 then 24..27,20..23.
- Continuous write and continuous read, 4 frames -> no overflow, no gaps after the first frame, and correct shifted order for every frame.
- i_Rd_En toggled 1,0,1,0 during read-out -> o_Rd_DV follows with 1-cycle lag, no sample skipped or repeated, and o_Rd_Data=0 when o_Rd_DV=0.
- Assert i_Rst after 5 writes, then write 8 new samples 30..37 -> first frame read back is 34..37,30..33; all outputs 0 the cycle after reset.
- With the macro defined, i_Shift_En=0 -> a frame of 0..7 reads 0..7; flipping i_Shift_En at mid-frame changes only the next frame.
